// File: rtl/i2s_tx_master.sv
// I2S transmit master with Philips framing: sck/ws are generated from clk_i by a
// programmable divider, and left/right words are served from an internal FIFO.
module i2s_tx_master #(
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned AW = $clog2(FIFO_DEPTH),
    localparam int unsigned LW = AW + 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en,
    input  logic [7:0]          prescale,
    input  logic                flush,
    input  logic [SAMPLE_W-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LW-1:0]       fifo_thr,
    output logic [LW-1:0]       fifo_level,
    output logic                underflow,
    input  logic                underflow_clr,
    output logic                irq,
    output logic                sck,
    output logic                ws,
    output logic                sdo
);
    localparam int unsigned BW = $clog2(SAMPLE_W);
    localparam logic [BW-1:0] LastBit = BW'(SAMPLE_W - 1);
    localparam logic [BW-1:0] LsbPrev = BW'(SAMPLE_W - 2);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StStop = 2'd2;

    logic [1:0]          state_q, state_d;
    logic                sck_q, sck_d;
    logic                ws_q, ws_d;
    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]          div_q, div_d;
    logic [7:0]          presc_q, presc_d;
    logic [AW:0]         wr_q, wr_d;
    logic [AW:0]         rd_q, rd_d;
    logic                underflow_q, underflow_d;
    logic                irq_q, irq_d;
    logic [SAMPLE_W-1:0] mem_q [FIFO_DEPTH];

    logic [LW-1:0] level;
    logic          empty, push, load, tc, fall;

    // FIFO bookkeeping; pointers carry one extra wrap bit so full != empty.
    always_comb begin
        level       = wr_q - rd_q;
        empty       = (level == '0);
        in_ready    = (level != LW'(FIFO_DEPTH));
        push        = in_valid && in_ready && !flush;
        wr_d        = flush ? '0 : wr_q + LW'(push);
        rd_d        = flush ? '0 : rd_q + LW'(load && !empty);
        underflow_d = (load && empty) ? 1'b1 : (underflow_clr ? 1'b0 : underflow_q);
        irq_d       = ((state_q == StRun) && (level <= fifo_thr)) || underflow_q;
    end

    always_comb begin
        state_d   = state_q;
        sck_d     = sck_q;
        ws_d      = ws_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        div_d     = div_q;
        presc_d   = presc_q;
        load      = 1'b0;
        tc        = (div_q == presc_q);
        fall      = tc && sck_q;
        case (state_q)
            StIdle: begin
                if (en && !empty) begin
                    state_d   = StRun;
                    presc_d   = prescale;
                    ws_d      = 1'b0;
                    sck_d     = 1'b0;
                    shift_d   = '0;
                    bit_cnt_d = LastBit;
                    div_d     = '0;
                end
            end
            default: begin
                if (state_q == StRun && !en) begin
                    state_d = StStop;
                end else if (state_q == StStop && en) begin
                    state_d = StRun;
                end
                if (tc) begin
                    div_d = '0;
                    sck_d = ~sck_q;
                end else begin
                    div_d = div_q + 8'd1;
                end
                if (fall) begin
                    if (bit_cnt_q == LastBit) begin
                        // ws low at a word boundary means the next slot is a left word.
                        if (state_q == StStop && !en && !ws_q) begin
                            state_d = StIdle;
                            sck_d   = 1'b0;
                            ws_d    = 1'b1;
                            shift_d = '0;
                            div_d   = '0;
                        end else begin
                            load      = 1'b1;
                            bit_cnt_d = '0;
                            shift_d   = empty ? '0 : mem_q[rd_q[AW-1:0]];
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shift_d   = {shift_q[SAMPLE_W-2:0], 1'b0};
                        if (bit_cnt_q == LsbPrev) begin
                            ws_d = ~ws_q;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            sck_q       <= 1'b0;
            ws_q        <= 1'b1;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            div_q       <= '0;
            presc_q     <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            underflow_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sck_q       <= sck_d;
            ws_q        <= ws_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            div_q       <= div_d;
            presc_q     <= presc_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            underflow_q <= underflow_d;
            irq_q       <= irq_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_q[AW-1:0]] <= in_data;
        end
    end

    assign fifo_level = level;
    assign underflow  = underflow_q;
    assign irq        = irq_q;
    assign sck        = sck_q;
    assign ws         = ws_q;
    assign sdo        = shift_q[SAMPLE_W-1];
endmodule

// File: tb/tb_i2s_tx_master.sv
// Bench for i2s_tx_master: a serial-bus receiver decodes sdo/ws and the decoded words
// are compared against a queue model of the FIFO contents.
module tb_i2s_tx_master;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        en;
    logic [7:0]  prescale;
    logic        flush;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  fifo_thr;
    logic [3:0]  fifo_level;
    logic        underflow;
    logic        underflow_clr;
    logic        irq;
    logic        sck;
    logic        ws;
    logic        sdo;

    i2s_tx_master #(.SAMPLE_W(16), .FIFO_DEPTH(8)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .en            (en),
        .prescale      (prescale),
        .flush         (flush),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .fifo_thr      (fifo_thr),
        .fifo_level    (fifo_level),
        .underflow     (underflow),
        .underflow_clr (underflow_clr),
        .irq           (irq),
        .sck           (sck),
        .ws            (ws),
        .sdo           (sdo)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: words the FIFO should hold, oldest first.
    logic [15:0] model_q[$];
    bit          uf_exp;

    // Bus receiver state.
    int          cyc;
    logic        sck_p, ws_p, p1, p2;
    bit          collecting, have_rise, started, got_fall;
    int          nb, dummy_bad, last_rise;
    int          per_min, per_max, hi_min, hi_max;
    int          ws_fall_cyc, first_fall_cyc;
    logic [15:0] cur;
    logic        cur_ch;
    logic [15:0] rx_w[$];
    logic        rx_c[$];
    logic        irq_mid;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic rx_reset();
        collecting = 0; have_rise = 0; started = 0; got_fall = 0;
        p1 = 1'b1; p2 = 1'b1; nb = 0; dummy_bad = 0;
        per_min = 1 << 30; per_max = 0; hi_min = 1 << 30; hi_max = 0;
        ws_fall_cyc = 0; first_fall_cyc = 0;
        rx_w.delete(); rx_c.delete();
    endtask

    // Philips receiver: a bit sampled on a rising edge belongs to the channel that ws
    // showed on the previous rising edge; a ws change there marks the next MSB.
    task automatic monitor_step();
        int d;
        cyc++;
        if (rst_i) begin
            sck_p = 1'b0;
            ws_p  = 1'b1;
        end else begin
            if (ws_p && !ws && !started) begin
                started = 1; ws_fall_cyc = cyc;
            end
            if (sck && !sck_p) begin
                if (have_rise) begin
                    d = cyc - last_rise;
                    if (d < per_min) per_min = d;
                    if (d > per_max) per_max = d;
                end
                last_rise = cyc; have_rise = 1;
                if (p1 != p2) begin
                    collecting = 1; cur_ch = p1; nb = 0; cur = '0;
                end
                if (collecting) begin
                    cur = {cur[14:0], sdo};
                    nb++;
                    if (nb == 16) begin
                        rx_w.push_back(cur); rx_c.push_back(cur_ch); collecting = 0;
                    end
                end else if (sdo) begin
                    dummy_bad++;
                end
                p2 = p1; p1 = ws;
            end
            if (!sck && sck_p) begin
                d = cyc - last_rise;
                if (d < hi_min) hi_min = d;
                if (d > hi_max) hi_max = d;
                if (started && !got_fall) begin
                    got_fall = 1; first_fall_cyc = cyc;
                end
            end
            sck_p = sck;
            ws_p  = ws;
        end
    endtask

    initial begin
        cyc = 0; sck_p = 1'b0; ws_p = 1'b1;
        rx_reset();
        forever begin
            @(negedge clk_i);
            monitor_step();
        end
    end

    task automatic push_word(input logic [15:0] w);
        @(posedge clk_i); #1;
        in_data = w; in_valid = 1'b1;
        @(posedge clk_i); #1;
        in_valid = 1'b0;
        model_q.push_back(w);
    endtask

    task automatic flush_fifo();
        @(posedge clk_i); #1; flush = 1'b1;
        @(posedge clk_i); #1; flush = 1'b0;
        model_q.delete();
    endtask

    task automatic clear_underflow();
        @(posedge clk_i); #1; underflow_clr = 1'b1;
        @(posedge clk_i); #1; underflow_clr = 1'b0;
        uf_exp = 0;
    endtask

    task automatic wait_idle(input int p);
        int quiet = 0;
        int budget = 0;
        while (quiet <= 2 * (p + 1) + 2 && budget < 6000) begin
            @(negedge clk_i);
            budget++;
            if (!sck && ws) quiet++;
            else quiet = 0;
        end
        check_eq("idle_wait", 32'(budget < 6000), 1);
    endtask

    // Start, drop en during bit 3 of word stop_idx (a left word), wait for the stop.
    task automatic run_frames(input int stop_idx, input int p, input int pm);
        int budget = 0;
        rx_reset();
        @(posedge clk_i); #1;
        prescale = 8'(p); en = 1'b1;
        while (!(rx_w.size() == stop_idx && collecting && nb == 3) && budget < 6000) begin
            @(posedge clk_i); #1;
            budget++;
            if (rx_w.size() >= 1) prescale = 8'(pm);
        end
        check_eq("start_wait", 32'(budget < 6000), 1);
        irq_mid = irq;
        en = 1'b0;
        wait_idle(p);
        check_eq("first_msb_latency", 32'(first_fall_cyc - ws_fall_cyc), 32'(2 * (p + 1)));
        check_eq("sck_period_min", 32'(per_min), 32'(2 * (p + 1)));
        check_eq("sck_period_max", 32'(per_max), 32'(2 * (p + 1)));
        check_eq("sck_high_min", 32'(hi_min), 32'(p + 1));
        check_eq("sck_high_max", 32'(hi_max), 32'(p + 1));
        check_eq("dummy_bit", 32'(dummy_bad), 0);
    endtask

    task automatic check_stream(input int n);
        logic [15:0] e;
        check_eq("rx_count", 32'(rx_w.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (model_q.size() > 0) begin
                e = model_q.pop_front();
            end else begin
                e = 16'h0; uf_exp = 1;
            end
            if (i < rx_w.size()) begin
                check_eq($sformatf("rx_word%0d", i), 32'(rx_w[i]), 32'(e));
                check_eq($sformatf("rx_chan%0d", i), 32'(rx_c[i]), 32'(i % 2));
            end
        end
        check_eq("level_after", 32'(fifo_level), 32'(model_q.size()));
        check_eq("underflow_after", 32'(underflow), 32'(uf_exp));
    endtask

    initial begin
        int acc;
        rst_i = 1'b1; en = 1'b0; prescale = 8'd0; flush = 1'b0; in_data = '0;
        in_valid = 1'b0; underflow_clr = 1'b0; fifo_thr = 4'd8; uf_exp = 0;
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_sck", 32'(sck), 0);
        check_eq("rst_ws", 32'(ws), 1);
        check_eq("rst_sdo", 32'(sdo), 0);
        check_eq("rst_level", 32'(fifo_level), 0);
        check_eq("rst_underflow", 32'(underflow), 0);
        check_eq("rst_irq", 32'(irq), 0);
        check_eq("rst_ready", 32'(in_ready), 1);
        rst_i = 1'b0;

        // Directed frame; third word must survive the stop.
        push_word(16'hA5F0); push_word(16'h0F5A); push_word(16'h1234);
        check_eq("level_3", 32'(fifo_level), 3);
        run_frames(0, 0, 0);
        check_eq("irq_run", 32'(irq_mid), 1);
        check_stream(2);
        check_eq("irq_idle", 32'(irq), 0);

        // Underflow on the right slot.
        run_frames(0, 0, 0);
        check_stream(2);
        check_eq("irq_underflow", 32'(irq), 1);
        clear_underflow();
        check_eq("underflow_cleared", 32'(underflow), 0);
        @(posedge clk_i); #1;
        check_eq("irq_cleared", 32'(irq), 0);
        push_word(16'h5555); push_word(16'h6666);
        run_frames(0, 0, 0);
        check_stream(2);

        // Backpressure and flush.
        @(posedge clk_i); #1;
        in_valid = 1'b1; acc = 0;
        for (int i = 0; i < 10; i++) begin
            in_data = 16'($urandom);
            @(negedge clk_i);
            if (in_ready) begin
                acc++; model_q.push_back(in_data);
            end
            @(posedge clk_i); #1;
        end
        check_eq("bp_accepted", 32'(acc), 8);
        check_eq("bp_ready", 32'(in_ready), 0);
        check_eq("bp_level", 32'(fifo_level), 8);
        flush = 1'b1;
        @(posedge clk_i); #1;
        flush = 1'b0; in_valid = 1'b0; model_q.delete();
        check_eq("flush_level", 32'(fifo_level), 0);
        push_word(16'h1111); push_word(16'h2222);
        @(posedge clk_i); #1;
        flush = 1'b1; in_valid = 1'b1; in_data = 16'h3333;
        @(posedge clk_i); #1;
        flush = 1'b0; in_valid = 1'b0; model_q.delete();
        check_eq("flush_drops_push", 32'(fifo_level), 0);

        // Divider: prescale 3, then a mid-run change that must not take effect.
        for (int i = 0; i < 4; i++) push_word(16'($urandom));
        run_frames(2, 3, 7);
        check_stream(4);

        // Randomized runs.
        for (int it = 0; it < 6; it++) begin
            int k, f, p, pm, lvl;
            flush_fifo();
            clear_underflow();
            k = $urandom_range(1, 8); f = $urandom_range(0, 2);
            p = $urandom_range(0, 3); pm = $urandom_range(0, 7);
            fifo_thr = 4'($urandom_range(0, 8));
            for (int j = 0; j < k; j++) push_word(16'($urandom));
            run_frames(2 * f, p, pm);
            lvl = (k > 2 * f + 1) ? k - (2 * f + 1) : 0;
            check_eq("irq_mid", 32'(irq_mid),
                     32'((lvl <= int'(fifo_thr)) || (k < 2 * f + 1)));
            check_stream(2 * f + 2);
        end

        // Asynchronous reset in the middle of a frame.
        flush_fifo();
        clear_underflow();
        fifo_thr = 4'd8;
        for (int i = 0; i < 4; i++) push_word(16'($urandom));
        @(posedge clk_i); #1;
        prescale = 8'd1; en = 1'b1;
        repeat (20) @(posedge clk_i);
        #3 rst_i = 1'b1;
        #1;
        check_eq("midrst_sck", 32'(sck), 0);
        check_eq("midrst_ws", 32'(ws), 1);
        check_eq("midrst_sdo", 32'(sdo), 0);
        check_eq("midrst_level", 32'(fifo_level), 0);
        check_eq("midrst_irq", 32'(irq), 0);
        en = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        model_q.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
